// File: rtl/mips_id_ex_stage_pkg.sv
// Shared widths, ALUctr codes, B-source selects and the ID/EX bundle layout.
package mips_id_ex_stage_pkg;

    localparam int DW  = 32;  // datapath width
    localparam int RW  = 5;   // register-address width
    localparam int OPW = 5;   // ALUctr width
    localparam int SHW = 5;   // shift-amount width

    // ALUctr codes; 0 is the bubble/no-op encoding
    localparam logic [OPW-1:0] ALU_NOP  = 5'd0;
    localparam logic [OPW-1:0] ALU_ADD  = 5'd1;
    localparam logic [OPW-1:0] ALU_ADDU = 5'd2;
    localparam logic [OPW-1:0] ALU_SUB  = 5'd3;
    localparam logic [OPW-1:0] ALU_SUBU = 5'd4;
    localparam logic [OPW-1:0] ALU_AND  = 5'd5;
    localparam logic [OPW-1:0] ALU_OR   = 5'd6;
    localparam logic [OPW-1:0] ALU_XOR  = 5'd7;
    localparam logic [OPW-1:0] ALU_NOR  = 5'd8;
    localparam logic [OPW-1:0] ALU_SLT  = 5'd9;
    localparam logic [OPW-1:0] ALU_SLTU = 5'd10;
    localparam logic [OPW-1:0] ALU_SLL  = 5'd11;
    localparam logic [OPW-1:0] ALU_SRL  = 5'd12;
    localparam logic [OPW-1:0] ALU_SRA  = 5'd13;
    localparam logic [OPW-1:0] ALU_SLLV = 5'd14;
    localparam logic [OPW-1:0] ALU_SRLV = 5'd15;
    localparam logic [OPW-1:0] ALU_SRAV = 5'd16;
    localparam logic [OPW-1:0] ALU_EQ   = 5'd17;
    localparam logic [OPW-1:0] ALU_LUI  = 5'd18;

    // B operand source
    localparam logic [1:0] BSEL_RT    = 2'd0;
    localparam logic [1:0] BSEL_IMM   = 2'd1;
    localparam logic [1:0] BSEL_SHAMT = 2'd2;

    // Contents of the ID/EX stage register; all-zero is a bubble
    typedef struct packed {
        logic           valid;
        logic [RW-1:0]  rs;
        logic [RW-1:0]  rt;
        logic [RW-1:0]  rd;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic [SHW-1:0] shamt;
        logic [OPW-1:0] opr;
        logic [1:0]     bsel;
        logic           regwrite;
        logic           memread;
        logic           memwrite;
    } idex_t;

endpackage

// File: rtl/mips_id_ex_stage_if.sv
// Decoded-instruction bus from ID into the ID/EX stage.
// Handshake: id_valid qualifies every id_* field in the same cycle; id_stall is
// the inverse of ready -- while it is high the stage does not consume the
// instruction and ID must present the same instruction again next cycle.
interface mips_id_ex_stage_if;
    import mips_id_ex_stage_pkg::*;

    logic           id_valid;
    logic [RW-1:0]  id_rs;
    logic [RW-1:0]  id_rt;
    logic [RW-1:0]  id_rd;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic [SHW-1:0] id_shamt;
    logic [OPW-1:0] id_opr;
    logic [1:0]     id_bsel;
    logic           id_regwrite;
    logic           id_memread;
    logic           id_memwrite;
    logic           id_stall;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_opr, id_bsel, id_regwrite, id_memread, id_memwrite,
        input  id_stall
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
               id_shamt, id_opr, id_bsel, id_regwrite, id_memread, id_memwrite,
        output id_stall
    );

endinterface

// File: rtl/mips_id_ex_stage_fwd_unit.sv
// One operand's forwarding select: EX/MEM result, MEM/WB data or the latched
// register-file value. $0 is never forwarded.
module mips_id_ex_stage_fwd_unit
    import mips_id_ex_stage_pkg::*;
(
    input  logic [RW-1:0] src,
    input  logic [DW-1:0] rf_data,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_res,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_data,
    output logic [DW-1:0] data
);

    // Youngest producer wins: EX/MEM before MEM/WB before the register file
    always_comb begin
        data = rf_data;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src)) begin
            data = exmem_res;
        end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src)) begin
            data = memwb_data;
        end
    end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch squash and operand
// forwarding into the ALU.
module mips_id_ex_stage
    import mips_id_ex_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    mips_id_ex_stage_if.slave   id,
    input  logic                exmem_regwrite,
    input  logic [RW-1:0]       exmem_rd,
    input  logic [DW-1:0]       exmem_res,
    input  logic                memwb_regwrite,
    input  logic [RW-1:0]       memwb_rd,
    input  logic [DW-1:0]       memwb_data,
    input  logic                ex_hold,
    input  logic                ex_flush,
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [OPW-1:0]      alu_opr,
    output logic                alu_cin,
    output logic                ex_valid,
    output logic [RW-1:0]       ex_rd,
    output logic                ex_regwrite,
    output logic                ex_memread,
    output logic                ex_memwrite,
    output logic [DW-1:0]       ex_store_data
);

    idex_t       q;
    idex_t       id_word;
    logic        load_use;
    logic        rt_needed;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // Pack the incoming ID fields into the stage-register layout
    always_comb begin
        id_word          = '0;
        id_word.valid    = 1'b1;
        id_word.rs       = id.id_rs;
        id_word.rt       = id.id_rt;
        id_word.rd       = id.id_rd;
        id_word.rs_data  = id.id_rs_data;
        id_word.rt_data  = id.id_rt_data;
        id_word.imm      = id.id_imm;
        id_word.shamt    = id.id_shamt;
        id_word.opr      = id.id_opr;
        id_word.bsel     = id.id_bsel;
        id_word.regwrite = id.id_regwrite;
        id_word.memread  = id.id_memread;
        id_word.memwrite = id.id_memwrite;
    end

    // A load in EX cannot forward in time to a dependent op in ID; rt only
    // counts when it is the B operand or store data
    always_comb begin
        rt_needed = (id.id_bsel == BSEL_RT) || id.id_memwrite;
        load_use  = q.valid && q.memread && (q.rd != '0) &&
                    ((q.rd == id.id_rs) || ((q.rd == id.id_rt) && rt_needed));
        id.id_stall = ex_hold || (load_use && !ex_flush);
    end

    // Stage register: reset > hold > flush > load-use bubble > load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ex_hold) begin
            q <= q;
        end else if (ex_flush || load_use || !id.id_valid) begin
            q <= '0;
        end else begin
            q <= id_word;
        end
    end

    mips_id_ex_stage_fwd_unit u_fwd_rs (
        .src            (q.rs),
        .rf_data        (q.rs_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rs)
    );

    mips_id_ex_stage_fwd_unit u_fwd_rt (
        .src            (q.rt),
        .rf_data        (q.rt_data),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .data           (fwd_rt)
    );

    // ALU operand steering; shifts take their value from rt on the A side
    always_comb begin
        alu_a = (q.bsel == BSEL_SHAMT) ? fwd_rt : fwd_rs;
        case (q.bsel)
            BSEL_IMM:   alu_b = q.imm;
            BSEL_SHAMT: alu_b = {{(DW-SHW){1'b0}}, q.shamt};
            default:    alu_b = fwd_rt;
        endcase
    end

    assign alu_opr       = q.opr;
    assign alu_cin       = 1'b0;
    assign ex_valid      = q.valid;
    assign ex_rd         = q.rd;
    assign ex_regwrite   = q.regwrite;
    assign ex_memread    = q.memread;
    assign ex_memwrite   = q.memwrite;
    assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Bench for mips_id_ex_stage: directed scenarios plus randomized traffic
// against a reference model of the stage contents.
module tb_mips_id_ex_stage;
    import mips_id_ex_stage_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mips_id_ex_stage_if idb ();

    logic          exmem_regwrite, memwb_regwrite, ex_hold, ex_flush;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_res, memwb_data;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [OPW-1:0] alu_opr;
    logic          alu_cin, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
    logic [RW-1:0] ex_rd;

    mips_id_ex_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id             (idb),
        .exmem_regwrite (exmem_regwrite),
        .exmem_rd       (exmem_rd),
        .exmem_res      (exmem_res),
        .memwb_regwrite (memwb_regwrite),
        .memwb_rd       (memwb_rd),
        .memwb_data     (memwb_data),
        .ex_hold        (ex_hold),
        .ex_flush       (ex_flush),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_opr        (alu_opr),
        .alu_cin        (alu_cin),
        .ex_valid       (ex_valid),
        .ex_rd          (ex_rd),
        .ex_regwrite    (ex_regwrite),
        .ex_memread     (ex_memread),
        .ex_memwrite    (ex_memwrite),
        .ex_store_data  (ex_store_data)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: the instruction sitting in EX (m_valid=0 means bubble)
    logic           m_valid, m_rw, m_mr, m_mw;
    logic [RW-1:0]  m_rs, m_rt, m_rd;
    logic [DW-1:0]  m_rs_data, m_rt_data, m_imm;
    logic [SHW-1:0] m_shamt;
    logic [OPW-1:0] m_opr;
    logic [1:0]     m_bsel;

    // Value a register read would see right now, newest producer first
    function automatic logic [DW-1:0] reg_value(input logic [RW-1:0] r, input logic [DW-1:0] rf);
        if (r == 0) return rf;
        if (exmem_regwrite && exmem_rd == r) return exmem_res;
        if (memwb_regwrite && memwb_rd == r) return memwb_data;
        return rf;
    endfunction

    // Does the ID instruction read the register a load in EX will produce?
    function automatic logic must_wait();
        logic reads_rt;
        if (!(m_valid && m_mr && m_rd != 0)) return 1'b0;
        reads_rt = (idb.id_bsel == 2'd0) || idb.id_memwrite;
        return (idb.id_rs == m_rd) || (reads_rt && idb.id_rt == m_rd);
    endfunction

    task automatic model_clear();
        m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        m_rs = 0; m_rt = 0; m_rd = 0; m_rs_data = 0; m_rt_data = 0;
        m_imm = 0; m_shamt = 0; m_opr = 0; m_bsel = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) model_clear();
        else if (ex_hold) ;
        else if (ex_flush || must_wait() || !idb.id_valid) model_clear();
        else begin
            m_valid = 1; m_rw = idb.id_regwrite; m_mr = idb.id_memread; m_mw = idb.id_memwrite;
            m_rs = idb.id_rs; m_rt = idb.id_rt; m_rd = idb.id_rd;
            m_rs_data = idb.id_rs_data; m_rt_data = idb.id_rt_data;
            m_imm = idb.id_imm; m_shamt = idb.id_shamt; m_opr = idb.id_opr; m_bsel = idb.id_bsel;
        end
    endtask

    task automatic check_model(input string tag);
        logic [DW-1:0] a_val, b_val, st_val;
        st_val = reg_value(m_rt, m_rt_data);
        a_val  = (m_bsel == 2'd2) ? st_val : reg_value(m_rs, m_rs_data);
        b_val  = (m_bsel == 2'd1) ? m_imm : (m_bsel == 2'd2) ? DW'(m_shamt) : st_val;
        check_eq({tag, ".stall"},   DW'(idb.id_stall), DW'(ex_hold | (must_wait() & ~ex_flush)));
        check_eq({tag, ".valid"},   DW'(ex_valid), DW'(m_valid));
        check_eq({tag, ".opr"},     DW'(alu_opr), DW'(m_opr));
        check_eq({tag, ".a"},       alu_a, a_val);
        check_eq({tag, ".b"},       alu_b, b_val);
        check_eq({tag, ".store"},   ex_store_data, st_val);
        check_eq({tag, ".cin"},     DW'(alu_cin), '0);
        check_eq({tag, ".ctl"},     DW'({ex_rd, ex_regwrite, ex_memread, ex_memwrite}),
                                    DW'({m_rd, m_rw, m_mr, m_mw}));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        idb.id_valid = 0; idb.id_rs = 0; idb.id_rt = 0; idb.id_rd = 0;
        idb.id_rs_data = 0; idb.id_rt_data = 0; idb.id_imm = 0; idb.id_shamt = 0;
        idb.id_opr = 0; idb.id_bsel = 0;
        idb.id_regwrite = 0; idb.id_memread = 0; idb.id_memwrite = 0;
        exmem_regwrite = 0; exmem_rd = 0; exmem_res = 0;
        memwb_regwrite = 0; memwb_rd = 0; memwb_data = 0;
        ex_hold = 0; ex_flush = 0;
    endtask

    task automatic drive_id(input logic [RW-1:0] rs, rt, rd, input logic [DW-1:0] rs_d, rt_d, imm,
                            input logic [SHW-1:0] sh, input logic [OPW-1:0] opr, input logic [1:0] bsel,
                            input logic rw, mr, mw);
        idb.id_valid = 1; idb.id_rs = rs; idb.id_rt = rt; idb.id_rd = rd;
        idb.id_rs_data = rs_d; idb.id_rt_data = rt_d; idb.id_imm = imm; idb.id_shamt = sh;
        idb.id_opr = opr; idb.id_bsel = bsel;
        idb.id_regwrite = rw; idb.id_memread = mr; idb.id_memwrite = mw;
    endtask

    task automatic random_inputs();
        drive_id(RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom, SHW'($urandom), OPW'($urandom_range(0, 18)),
                 2'($urandom_range(0, 2)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 4) == 0));
        idb.id_valid   = ($urandom_range(0, 5) != 0);
        exmem_regwrite = 1'($urandom); exmem_rd = RW'($urandom_range(0, 3)); exmem_res = $urandom;
        memwb_regwrite = 1'($urandom); memwb_rd = RW'($urandom_range(0, 3)); memwb_data = $urandom;
        ex_hold  = ($urandom_range(0, 7) == 0);
        ex_flush = ($urandom_range(0, 7) == 0);
        rst_n    = ($urandom_range(0, 49) != 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        model_clear();
        rst_n = 0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1;
        #1;
        check_model("reset");
        check_eq("reset.valid_const", DW'(ex_valid), '0);
        check_eq("reset.opr_const", DW'(alu_opr), DW'(ALU_NOP));

        // 1: EX/MEM wins over MEM/WB for the same register
        drive_id(1, 2, 3, 32'h111, 32'h222, 0, 0, ALU_ADD, BSEL_RT, 1, 0, 0);
        tick();
        idb.id_valid = 0;
        exmem_regwrite = 1; exmem_rd = 1; exmem_res = 32'h10;
        memwb_regwrite = 1; memwb_rd = 1; memwb_data = 32'h20;
        #1;
        check_model("t1");
        check_eq("t1.exmem_prio", alu_a, 32'h10);
        check_eq("t1.rt_rf", alu_b, 32'h222);

        // 2: load-use produces one bubble, then MEM/WB forward
        idle_inputs();
        drive_id(1, 0, 5, 0, 0, 32'h4, 0, ALU_ADD, BSEL_IMM, 1, 1, 0);
        tick();
        drive_id(5, 0, 6, 32'hBAD, 0, 0, 0, ALU_ADD, BSEL_RT, 1, 0, 0);
        #1;
        check_model("t2a");
        check_eq("t2.stall", DW'(idb.id_stall), 1);
        tick();
        check_model("t2b");
        check_eq("t2.bubble", DW'(ex_valid), 0);
        check_eq("t2.stall_clr", DW'(idb.id_stall), 0);
        tick();
        idb.id_valid = 0;
        memwb_regwrite = 1; memwb_rd = 5; memwb_data = 32'hCAFE;
        #1;
        check_model("t2c");
        check_eq("t2.memwb_fwd", alu_a, 32'hCAFE);

        // 3: flush beats load-use
        idle_inputs();
        drive_id(1, 0, 5, 0, 0, 32'h4, 0, ALU_ADD, BSEL_IMM, 1, 1, 0);
        tick();
        drive_id(5, 0, 6, 0, 0, 0, 0, ALU_ADD, BSEL_RT, 1, 0, 0);
        ex_flush = 1;
        #1;
        check_model("t3a");
        check_eq("t3.no_stall", DW'(idb.id_stall), 0);
        tick();
        check_model("t3b");
        check_eq("t3.squash_valid", DW'(ex_valid), 0);
        check_eq("t3.squash_opr", DW'(alu_opr), 0);

        // 4: $0 never forwarded
        idle_inputs();
        drive_id(0, 0, 4, 0, 0, 0, 0, ALU_ADD, BSEL_RT, 1, 0, 0);
        tick();
        idb.id_valid = 0;
        exmem_regwrite = 1; exmem_rd = 0; exmem_res = 32'hDEAD;
        #1;
        check_model("t4");
        check_eq("t4.zero_reg", alu_a, 0);

        // 5: shift and immediate B sources
        idle_inputs();
        drive_id(0, 2, 4, 32'h99, 32'h1, 32'h77, 5'd4, ALU_SLL, BSEL_SHAMT, 1, 0, 0);
        tick();
        drive_id(0, 0, 4, 0, 0, 32'h1234, 0, ALU_LUI, BSEL_IMM, 1, 0, 0);
        #1;
        check_model("t5a");
        check_eq("t5.sll_a", alu_a, 32'h1);
        check_eq("t5.sll_b", alu_b, 32'h4);
        tick();
        check_model("t5b");
        check_eq("t5.lui_b", alu_b, 32'h1234);

        // 6: hold with flush freezes; reset during hold clears
        idle_inputs();
        drive_id(1, 2, 7, 32'h5, 32'h6, 0, 0, ALU_SUB, BSEL_RT, 1, 0, 1);
        tick();
        drive_id(3, 3, 9, 32'hAA, 32'hBB, 0, 0, ALU_OR, BSEL_RT, 1, 0, 0);
        ex_hold = 1; ex_flush = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("t6hold");
            check_eq("t6.hold_valid", DW'(ex_valid), 1);
            check_eq("t6.hold_rd", DW'(ex_rd), 7);
            check_eq("t6.hold_opr", DW'(alu_opr), DW'(ALU_SUB));
        end
        rst_n = 0;
        tick();
        rst_n = 1;
        idle_inputs();
        #1;
        check_model("t6rst");
        check_eq("t6.rst_valid", DW'(ex_valid), 0);
        check_eq("t6.rst_rd", DW'(ex_rd), 0);
        check_eq("t6.rst_a", alu_a, 0);
        check_eq("t6.rst_ctl", DW'({ex_regwrite, ex_memread, ex_memwrite}), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            random_inputs();
            #1;
            check_model("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Bound on total runtime
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
